// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, parity modes, per-frame
// status flags and the baud-divider derivation used by both rx and tx.
package uart_pkg;

    // One-hot receiver states
    localparam logic [5:0] ST_IDLE     = 6'b000001;
    localparam logic [5:0] ST_START    = 6'b000010;
    localparam logic [5:0] ST_DATA     = 6'b000100;
    localparam logic [5:0] ST_PARITY   = 6'b001000;
    localparam logic [5:0] ST_STOP     = 6'b010000;
    localparam logic [5:0] ST_BRK_WAIT = 6'b100000;

    // Parity modes
    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    // Status flags that travel with a received word
    typedef struct packed {
        logic parity_err;
        logic frame_err;
        logic break_det;
    } rx_flags_t;

    // Clock cycles per bit, rounded to nearest
    function automatic int calc_bit_cnt(input int clk_freq, input int baud);
        return (clk_freq + baud / 2) / baud;
    endfunction

    // Half a bit time, used to find the bit centre
    function automatic int calc_half(input int clk_freq, input int baud);
        return calc_bit_cnt(clk_freq, baud) / 2;
    endfunction

endpackage

// File: rtl/uart_bit_sampler.sv
// Line front end for the UART receiver: metastability synchroniser, falling
// edge detector, per-bit cycle counter and a three-sample majority vote taken
// around the middle of each bit.
module uart_bit_sampler
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD     = 115200
) (
    input  logic sys_clk,
    input  logic rst_n,
    input  logic uartrx,
    input  logic run,
    output logic rx_line,
    output logic fall_edge,
    output logic bit_val,
    output logic bit_strobe,
    output logic bit_end
);

    localparam int BIT_CNT = calc_bit_cnt(CLK_FREQ, BAUD);
    localparam int HALF    = calc_half(CLK_FREQ, BAUD);
    localparam int CNT_W   = $clog2(BIT_CNT);

    logic             rx_meta;
    logic             rx_sync;
    logic             rx_prev;
    logic [CNT_W-1:0] cnt;
    logic             samp_a;
    logic             samp_b;

    // Two-flop synchroniser plus a history flop; idle line is high
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= uartrx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    assign rx_line   = rx_sync;
    assign fall_edge = rx_prev & ~rx_sync;

    // Bit-time counter; parked at 0 whenever the receiver is not in a frame
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (!run || (cnt == CNT_W'(BIT_CNT - 1))) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Capture the two samples that precede the voting cycle
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            samp_a <= 1'b0;
            samp_b <= 1'b0;
        end else begin
            if (cnt == CNT_W'(HALF - 1)) begin
                samp_a <= rx_sync;
            end
            if (cnt == CNT_W'(HALF)) begin
                samp_b <= rx_sync;
            end
        end
    end

    // Third sample is the live synchronised line at HALF+1
    assign bit_val    = (samp_a & samp_b) | (samp_a & rx_sync) | (samp_b & rx_sync);
    assign bit_strobe = run && (cnt == CNT_W'(HALF + 1));
    assign bit_end    = run && (cnt == CNT_W'(BIT_CNT - 1));

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: 5..9 data bits, none/odd/even parity, one or
// two stop bits. Frames are delivered through a one-entry valid/ready holding
// register together with parity, framing, break and overrun flags.
module uart_rx_cfg
    import uart_pkg::*;
#(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int BAUD      = 115200,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 sys_clk,
    input  logic                 rst_n,
    input  logic                 uartrx,
    output logic [DATA_BITS-1:0] odat,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 break_det,
    output logic                 overrun,
    output logic                 rx_busy
);

    logic                 rx_line;
    logic                 fall_edge;
    logic                 bit_val;
    logic                 bit_strobe;
    logic                 bit_end;
    logic                 run;

    logic [5:0]           state;
    logic [3:0]           bit_idx;
    logic                 stop_idx;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_bit;
    logic                 par_err_r;
    logic                 frm_err_r;

    logic                 exp_par;
    logic                 frame_now;
    logic                 last_stop;
    logic                 commit;
    logic                 brk_now;
    rx_flags_t            commit_flags;

    assign run     = (state != ST_IDLE) && (state != ST_BRK_WAIT);
    assign rx_busy = (state != ST_IDLE);

    uart_bit_sampler #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD     (BAUD)
    ) u_sampler (
        .sys_clk    (sys_clk),
        .rst_n      (rst_n),
        .uartrx     (uartrx),
        .run        (run),
        .rx_line    (rx_line),
        .fall_edge  (fall_edge),
        .bit_val    (bit_val),
        .bit_strobe (bit_strobe),
        .bit_end    (bit_end)
    );

    // Frame-level decisions made at the last stop bit's voting point
    always_comb begin
        exp_par   = (PARITY == PARITY_ODD) ? ~(^shreg) : (^shreg);
        frame_now = frm_err_r | ~bit_val;
        last_stop = (stop_idx == 1'(STOP_BITS - 1));
        commit    = (state == ST_STOP) && bit_strobe && last_stop;
        brk_now   = (shreg == '0) && ((PARITY == PARITY_NONE) || !par_bit) && frame_now;
        commit_flags.parity_err = (PARITY != PARITY_NONE) && par_err_r;
        commit_flags.frame_err  = frame_now;
        commit_flags.break_det  = brk_now;
    end

    // Receive state machine and data/parity/stop bookkeeping
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            bit_idx   <= '0;
            stop_idx  <= 1'b0;
            shreg     <= '0;
            par_bit   <= 1'b0;
            par_err_r <= 1'b0;
            frm_err_r <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (fall_edge) begin
                        state <= ST_START;
                    end
                end
                ST_START: begin
                    bit_idx   <= '0;
                    stop_idx  <= 1'b0;
                    par_bit   <= 1'b0;
                    par_err_r <= 1'b0;
                    frm_err_r <= 1'b0;
                    if (bit_strobe && bit_val) begin
                        state <= ST_IDLE;
                    end else if (bit_end) begin
                        state <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (bit_strobe) begin
                        shreg <= {bit_val, shreg[DATA_BITS-1:1]};
                    end
                    if (bit_end) begin
                        if (bit_idx == 4'(DATA_BITS - 1)) begin
                            bit_idx <= '0;
                            state   <= (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end
                end
                ST_PARITY: begin
                    if (bit_strobe) begin
                        par_bit   <= bit_val;
                        par_err_r <= (bit_val != exp_par);
                    end
                    if (bit_end) begin
                        state <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (bit_strobe) begin
                        frm_err_r <= frame_now;
                        if (last_stop) begin
                            state <= brk_now ? ST_BRK_WAIT : ST_IDLE;
                        end else begin
                            stop_idx <= stop_idx + 1'b1;
                        end
                    end
                end
                ST_BRK_WAIT: begin
                    if (rx_line) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // One-entry holding register; a new word always replaces an old one
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            odat       <= '0;
            out_valid  <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            break_det  <= 1'b0;
            overrun    <= 1'b0;
        end else if (commit) begin
            odat       <= shreg;
            parity_err <= commit_flags.parity_err;
            frame_err  <= commit_flags.frame_err;
            break_det  <= commit_flags.break_det;
            out_valid  <= 1'b1;
            overrun    <= out_valid && !out_ready;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Self-checking bench for uart_rx_cfg. Three receivers with different frame
// formats share clock and reset; each has its own line and ready input.
module tb_uart_rx_cfg;

    localparam int CLK_FREQ = 1_600_000;
    localparam int BAUD     = 100_000;
    localparam int BITC     = 16;

    typedef struct packed {
        logic [8:0] d;
        logic       pe;
        logic       fe;
        logic       bk;
        logic       ov;
    } word_t;

    logic sys_clk = 1'b0;
    logic rst_n   = 1'b1;
    logic rx_a    = 1'b1;
    logic rx_b    = 1'b1;
    logic rx_c    = 1'b1;
    logic rdy_a   = 1'b1;
    logic rdy_b   = 1'b1;
    logic rdy_c   = 1'b1;

    logic [7:0] odat_a;
    logic [7:0] odat_b;
    logic [8:0] odat_c;
    logic val_a, pe_a, fe_a, bk_a, ov_a, busy_a;
    logic val_b, pe_b, fe_b, bk_b, ov_b, busy_b;
    logic val_c, pe_c, fe_c, bk_c, ov_c, busy_c;

    int checks = 0;
    int errors = 0;

    word_t q_a[$];
    word_t q_b[$];
    word_t q_c[$];

    always #5 sys_clk = ~sys_clk;

    // dut_a: 8N1, dut_b: 8E1, dut_c: 9O2
    uart_rx_cfg #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut_a (
        .sys_clk(sys_clk), .rst_n(rst_n), .uartrx(rx_a), .odat(odat_a), .out_valid(val_a),
        .out_ready(rdy_a), .parity_err(pe_a), .frame_err(fe_a), .break_det(bk_a),
        .overrun(ov_a), .rx_busy(busy_a));

    uart_rx_cfg #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) dut_b (
        .sys_clk(sys_clk), .rst_n(rst_n), .uartrx(rx_b), .odat(odat_b), .out_valid(val_b),
        .out_ready(rdy_b), .parity_err(pe_b), .frame_err(fe_b), .break_det(bk_b),
        .overrun(ov_b), .rx_busy(busy_b));

    uart_rx_cfg #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .DATA_BITS(9), .PARITY(1), .STOP_BITS(2)) dut_c (
        .sys_clk(sys_clk), .rst_n(rst_n), .uartrx(rx_c), .odat(odat_c), .out_valid(val_c),
        .out_ready(rdy_c), .parity_err(pe_c), .frame_err(fe_c), .break_det(bk_c),
        .overrun(ov_c), .rx_busy(busy_c));

    // Record every accepted word per receiver
    always @(negedge sys_clk) begin
        if (rst_n === 1'b1) begin
            if (val_a && rdy_a) q_a.push_back({1'b0, odat_a, pe_a, fe_a, bk_a, ov_a});
            if (val_b && rdy_b) q_b.push_back({1'b0, odat_b, pe_b, fe_b, bk_b, ov_b});
            if (val_c && rdy_c) q_c.push_back({odat_c, pe_c, fe_c, bk_c, ov_c});
        end
    end

    // Parity bit a correct transmitter would send
    function automatic logic good_par(input logic [8:0] d, input int nbits, input int pmode);
        int ones = 0;
        for (int i = 0; i < nbits; i++) ones += int'(d[i]);
        return (pmode == 1) ? ((ones % 2) == 0) : ((ones % 2) == 1);
    endfunction

    // Expected receiver report for a frame described by its line bits
    function automatic word_t model(input logic [8:0] d, input int nbits, input int pmode,
                                    input logic pbit, input logic [1:0] stops, input int nstop);
        word_t w;
        logic [8:0] m = '0;
        for (int i = 0; i < nbits; i++) m[i] = d[i];
        w.d  = m;
        w.pe = (pmode != 0) && (pbit != good_par(m, nbits, pmode));
        w.fe = !stops[0] || ((nstop == 2) && !stops[1]);
        w.bk = (m == '0) && ((pmode == 0) || !pbit) && w.fe;
        w.ov = 1'b0;
        return w;
    endfunction

    task automatic set_line(input int which, input logic v);
        case (which)
            0: rx_a = v;
            1: rx_b = v;
            default: rx_c = v;
        endcase
    endtask

    // Drive one frame bit by bit, leaving the line idle high afterwards
    task automatic send_frame(input int which, input logic [8:0] d, input int nbits, input int pmode,
                              input logic pbit, input logic [1:0] stops, input int nstop);
        logic bits[$];
        bits.push_back(1'b0);
        for (int i = 0; i < nbits; i++) bits.push_back(d[i]);
        if (pmode != 0) bits.push_back(pbit);
        for (int s = 0; s < nstop; s++) bits.push_back(stops[s]);
        foreach (bits[i]) begin
            set_line(which, bits[i]);
            repeat (BITC) @(posedge sys_clk);
        end
        set_line(which, 1'b1);
    endtask

    task automatic idle_bits(input int n);
        repeat (n * BITC) @(posedge sys_clk);
    endtask

    function automatic int qsize(input int which);
        case (which)
            0: return q_a.size();
            1: return q_b.size();
            default: return q_c.size();
        endcase
    endfunction

    // Wait (bounded) for a word and pop it; yields all-X on timeout
    task automatic fetch(input int which, output word_t w);
        int c = 0;
        while (qsize(which) == 0 && c < 600) begin
            @(negedge sys_clk);
            c++;
        end
        #1;
        if (qsize(which) == 0) begin
            $display("[TB] timeout waiting for word on receiver %0d", which);
            w = 'x;
        end else begin
            case (which)
                0: w = q_a.pop_front();
                1: w = q_b.pop_front();
                default: w = q_c.pop_front();
            endcase
        end
    endtask

    task automatic test_reset();
        @(negedge sys_clk);
        rst_n = 1'b0;
        repeat (3) @(negedge sys_clk);
        checks++;
        if ({odat_a, val_a, pe_a, fe_a, bk_a, ov_a, busy_a} !== '0) begin
            errors++; $display("[TB] FAIL reset_a: got %h required 0", {odat_a, val_a, pe_a, fe_a, bk_a, ov_a, busy_a});
        end
        checks++;
        if ({odat_b, val_b, pe_b, fe_b, bk_b, ov_b, busy_b} !== '0) begin
            errors++; $display("[TB] FAIL reset_b: got %h required 0", {odat_b, val_b, pe_b, fe_b, bk_b, ov_b, busy_b});
        end
        checks++;
        if ({odat_c, val_c, pe_c, fe_c, bk_c, ov_c, busy_c} !== '0) begin
            errors++; $display("[TB] FAIL reset_c: got %h required 0", {odat_c, val_c, pe_c, fe_c, bk_c, ov_c, busy_c});
        end
        rst_n = 1'b1;
        idle_bits(2);
        @(negedge sys_clk);
        checks++;
        if ({busy_a, busy_b, busy_c, val_a, val_b, val_c} !== 6'b0) begin
            errors++; $display("[TB] FAIL idle_after_reset: got %b required 000000", {busy_a, busy_b, busy_c, val_a, val_b, val_c});
        end
    endtask

    task automatic test_basic();
        word_t w, e;
        e = model(9'h0A5, 8, 0, 1'b0, 2'b11, 1);
        send_frame(0, 9'h0A5, 8, 0, 1'b0, 2'b11, 1);
        fetch(0, w);
        checks++;
        if (w !== e) begin errors++; $display("[TB] FAIL basic_a5: got %h required %h", w, e); end
        idle_bits(2);
        checks++;
        if (q_a.size() != 0) begin errors++; $display("[TB] FAIL basic_single_pulse: extra words %0d required 0", q_a.size()); end
    endtask

    task automatic test_parity();
        word_t w, e;
        e = model(9'h007, 8, 2, 1'b1, 2'b11, 1);
        send_frame(1, 9'h007, 8, 2, 1'b1, 2'b11, 1);
        fetch(1, w);
        checks++;
        if (w !== e) begin errors++; $display("[TB] FAIL parity_good: got %h required %h", w, e); end
        idle_bits(2);
        e = model(9'h007, 8, 2, 1'b0, 2'b11, 1);
        send_frame(1, 9'h007, 8, 2, 1'b0, 2'b11, 1);
        fetch(1, w);
        checks++;
        if (w !== e) begin errors++; $display("[TB] FAIL parity_bad: got %h required %h", w, e); end
        idle_bits(2);
    endtask

    task automatic test_glitch();
        word_t w, e;
        @(posedge sys_clk);
        set_line(0, 1'b0);
        repeat (4) @(posedge sys_clk);
        set_line(0, 1'b1);
        @(negedge sys_clk);
        checks++;
        if (busy_a !== 1'b1) begin errors++; $display("[TB] FAIL glitch_start: busy %b required 1", busy_a); end
        idle_bits(3);
        checks++;
        if ({busy_a, val_a} !== 2'b00 || q_a.size() != 0) begin
            errors++; $display("[TB] FAIL glitch_reject: busy/valid %b words %0d required 00 and 0", {busy_a, val_a}, q_a.size());
        end
        e = model(9'h03C, 8, 0, 1'b0, 2'b11, 1);
        send_frame(0, 9'h03C, 8, 0, 1'b0, 2'b11, 1);
        fetch(0, w);
        checks++;
        if (w !== e) begin errors++; $display("[TB] FAIL glitch_then_3c: got %h required %h", w, e); end
        idle_bits(2);
    endtask

    task automatic test_framing_break();
        word_t w, e;
        logic [8:0] d;
        e = model(9'h055, 8, 0, 1'b0, 2'b10, 1);
        send_frame(0, 9'h055, 8, 0, 1'b0, 2'b10, 1);
        fetch(0, w);
        checks++;
        if (w !== e) begin errors++; $display("[TB] FAIL framing_55: got %h required %h", w, e); end
        idle_bits(2);
        set_line(0, 1'b0);
        idle_bits(20);
        @(negedge sys_clk);
        checks++;
        if (busy_a !== 1'b1) begin errors++; $display("[TB] FAIL break_hold_busy: busy %b required 1", busy_a); end
        checks++;
        if (q_a.size() != 1) begin errors++; $display("[TB] FAIL break_count: words %0d required 1", q_a.size()); end
        e = model(9'h000, 8, 0, 1'b0, 2'b00, 1);
        fetch(0, w);
        checks++;
        if (w !== e) begin errors++; $display("[TB] FAIL break_word: got %h required %h", w, e); end
        set_line(0, 1'b1);
        idle_bits(3);
        @(negedge sys_clk);
        checks++;
        if (busy_a !== 1'b0 || q_a.size() != 0) begin
            errors++; $display("[TB] FAIL break_release: busy %b words %0d required 0 and 0", busy_a, q_a.size());
        end
        d = 9'($urandom_range(1, 255));
        e = model(d, 8, 0, 1'b0, 2'b11, 1);
        send_frame(0, d, 8, 0, 1'b0, 2'b11, 1);
        fetch(0, w);
        checks++;
        if (w !== e) begin errors++; $display("[TB] FAIL after_break_word: got %h required %h", w, e); end
        idle_bits(2);
    endtask

    task automatic test_overrun();
        word_t w, e;
        @(posedge sys_clk); #1;
        rdy_a = 1'b0;
        send_frame(0, 9'h011, 8, 0, 1'b0, 2'b11, 1);
        send_frame(0, 9'h022, 8, 0, 1'b0, 2'b11, 1);
        idle_bits(1);
        @(negedge sys_clk);
        checks++;
        if (val_a !== 1'b1) begin errors++; $display("[TB] FAIL overrun_pending: valid %b required 1", val_a); end
        @(posedge sys_clk); #1;
        rdy_a = 1'b1;
        @(negedge sys_clk);
        @(negedge sys_clk); #1;
        checks++;
        if (q_a.size() != 1) begin errors++; $display("[TB] FAIL overrun_once: words %0d required 1", q_a.size()); end
        checks++;
        if (val_a !== 1'b0) begin errors++; $display("[TB] FAIL overrun_valid_drop: valid %b required 0", val_a); end
        e = model(9'h022, 8, 0, 1'b0, 2'b11, 1);
        e.ov = 1'b1;
        fetch(0, w);
        checks++;
        if (w !== e) begin errors++; $display("[TB] FAIL overrun_word: got %h required %h", w, e); end
        idle_bits(2);
    endtask

    task automatic test_back_to_back();
        word_t exp_q[$];
        word_t w, e;
        logic [8:0] d;
        for (int i = 0; i < 5; i++) begin
            d = 9'($urandom_range(0, 255));
            exp_q.push_back(model(d, 8, 0, 1'b0, 2'b11, 1));
            send_frame(0, d, 8, 0, 1'b0, 2'b11, 1);
        end
        foreach (exp_q[i]) begin
            e = exp_q[i];
            fetch(0, w);
            checks++;
            if (w !== e) begin errors++; $display("[TB] FAIL b2b_%0d: got %h required %h", i, w, e); end
        end
        idle_bits(2);
    endtask

    task automatic test_random_cfg();
        word_t w, e;
        logic [8:0] d;
        logic pbit;
        logic [1:0] stops;
        for (int i = 0; i < 12; i++) begin
            int which = (i % 2 == 0) ? 1 : 2;
            int nbits = (which == 1) ? 8 : 9;
            int pmode = (which == 1) ? 2 : 1;
            int nstop = (which == 1) ? 1 : 2;
            d = 9'($urandom_range(0, (1 << nbits) - 1));
            pbit = good_par(d, nbits, pmode) ^ ($urandom_range(0, 2) == 0);
            stops = 2'b11;
            if ($urandom_range(0, 3) == 0) stops[$urandom_range(0, nstop - 1)] = 1'b0;
            e = model(d, nbits, pmode, pbit, stops, nstop);
            send_frame(which, d, nbits, pmode, pbit, stops, nstop);
            fetch(which, w);
            checks++;
            if (w !== e) begin errors++; $display("[TB] FAIL random_%0d rx%0d: got %h required %h", i, which, w, e); end
            idle_bits(2);
        end
    endtask

    task automatic test_nine_bit_reset();
        word_t w, e;
        e = model(9'h1FF, 9, 1, good_par(9'h1FF, 9, 1), 2'b11, 2);
        send_frame(2, 9'h1FF, 9, 1, good_par(9'h1FF, 9, 1), 2'b11, 2);
        fetch(2, w);
        checks++;
        if (w !== e) begin errors++; $display("[TB] FAIL nine_bit_1ff: got %h required %h", w, e); end
        idle_bits(2);
        @(posedge sys_clk);
        set_line(2, 1'b0);
        repeat (3 * BITC) @(posedge sys_clk);
        @(negedge sys_clk);
        checks++;
        if (busy_c !== 1'b1) begin errors++; $display("[TB] FAIL mid_frame_busy: busy %b required 1", busy_c); end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({odat_c, val_c, pe_c, fe_c, bk_c, ov_c, busy_c} !== '0) begin
            errors++; $display("[TB] FAIL mid_frame_reset: got %h required 0", {odat_c, val_c, pe_c, fe_c, bk_c, ov_c, busy_c});
        end
        set_line(2, 1'b1);
        repeat (3) @(negedge sys_clk);
        rst_n = 1'b1;
        idle_bits(16);
        @(negedge sys_clk);
        checks++;
        if (q_c.size() != 0 || val_c !== 1'b0 || busy_c !== 1'b0) begin
            errors++; $display("[TB] FAIL no_partial_word: words %0d valid %b busy %b required 0", q_c.size(), val_c, busy_c);
        end
    endtask

    // Overall time bound
    initial begin
        #5ms;
        $display("[TB] FAIL watchdog: simulation did not complete, checks %0d errors %0d", checks, errors);
        $fatal(1, "[TB] watchdog expired");
    end

    // Test sequence
    initial begin
        $display("[TB] uart_rx_cfg bench start");
        test_reset();
        test_basic();
        test_parity();
        test_glitch();
        test_framing_break();
        test_overrun();
        test_back_to_back();
        test_random_cfg();
        test_nine_bit_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
